// File: rtl/seq_mul8.sv
// -----------------------------------------------------------------------------
// seq_mul8 -- sequential 8x8 unsigned shift-and-add multiplier.
//
// One operand pair is accepted per start pulse. Eight RUN cycles each add the
// multiplicand (or zero) into the high half of the product through the 8-bit
// carry-select adder, then shift {carry, sum, Q} right by one. The 16-bit
// product is registered on the DONE-entry edge and held until the next result.
//
// Ports
//   clk    in   1   rising-edge clock
//   rst    in   1   asynchronous, active-high reset
//   start  in   1   request; sampled only in IDLE or DONE
//   x      in   8   multiplicand, latched on an accepted start
//   y      in   8   multiplier, latched on an accepted start
//   busy   out  1   high while in RUN
//   done   out  1   one-cycle pulse; z is new in that cycle
//   z      out 16   registered product
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// cse_add8 -- 8-bit carry-select adder.
// The low nibble ripples; the high nibble is computed for both possible
// incoming carries and the low-nibble carry selects the right one.
//
// Ports
//   i_a, i_b  in   8   addends
//   i_ci      in   1   carry in
//   o_s       out  8   sum
//   o_co      out  1   carry out
// -----------------------------------------------------------------------------
module cse_add8 (
   input  logic [7:0] i_a,
   input  logic [7:0] i_b,
   input  logic       i_ci,
   output logic [7:0] o_s,
   output logic       o_co
);

   logic [4:0] w_lo;
   logic [4:0] w_hi0;
   logic [4:0] w_hi1;

   assign w_lo  = {1'b0, i_a[3:0]} + {1'b0, i_b[3:0]} + {4'b0000, i_ci};
   assign w_hi0 = {1'b0, i_a[7:4]} + {1'b0, i_b[7:4]};
   assign w_hi1 = {1'b0, i_a[7:4]} + {1'b0, i_b[7:4]} + 5'd1;

   assign o_s  = {(w_lo[4] ? w_hi1[3:0] : w_hi0[3:0]), w_lo[3:0]};
   assign o_co = w_lo[4] ? w_hi1[4] : w_hi0[4];

endmodule

module seq_mul8 (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  x,
   input  logic [7:0]  y,
   output logic        busy,
   output logic        done,
   output logic [15:0] z
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      r_state;
   logic [7:0]  r_m;     // latched multiplicand
   logic [7:0]  r_a;     // accumulator, product high half
   logic [7:0]  r_q;     // multiplier, becomes product low half
   logic [2:0]  r_cnt;   // step counter, 0..7
   logic [15:0] r_z;     // result register

   logic [7:0]  w_addend;
   logic [7:0]  w_s;
   logic        w_c;
   logic [15:0] w_next_aq;

   // Add M only when the current multiplier LSB is set.
   assign w_addend = r_q[0] ? r_m : 8'h00;

   cse_add8 u_add (
      .i_a  (r_a),
      .i_b  (w_addend),
      .i_ci (1'b0),
      .o_s  (w_s),
      .o_co (w_c)
   );

   // {c, s, Q} shifted right by one: the adder carry lands in A[7], so no
   // bit of the partial product is ever lost.
   assign w_next_aq = {w_c, w_s, r_q[7:1]};

   // NOTE: all state is updated with non-blocking assignments so every
   // register samples the pre-edge values, matching the hardware it models.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_m     <= 8'h00;
         r_a     <= 8'h00;
         r_q     <= 8'h00;
         r_cnt   <= 3'd0;
         r_z     <= 16'h0000;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_m     <= x;
                  r_q     <= y;
                  r_a     <= 8'h00;
                  r_cnt   <= 3'd0;
                  r_state <= S_RUN;
               end
            end

            S_RUN: begin
               {r_a, r_q} <= w_next_aq;
               r_cnt      <= r_cnt + 3'd1;
               // The eighth step still executes; its result is the product.
               if (r_cnt == 3'd7) begin
                  r_z     <= w_next_aq;
                  r_state <= S_DONE;
               end
            end

            S_DONE: begin
               if (start) begin
                  r_m     <= x;
                  r_q     <= y;
                  r_a     <= 8'h00;
                  r_cnt   <= 3'd0;
                  r_state <= S_RUN;
               end else begin
                  r_state <= S_IDLE;
               end
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Moore outputs decoded straight from the state register.
   assign busy = (r_state == S_RUN);
   assign done = (r_state == S_DONE);
   assign z    = r_z;

endmodule

// File: tb/tb_seq_mul8.sv
// -----------------------------------------------------------------------------
// tb_seq_mul8 -- self-checking bench for seq_mul8.
// Expected products come from plain integer multiplication of the operands
// presented at start; cycle timing is checked against the 8-clock latency and
// one-cycle done pulse.
// -----------------------------------------------------------------------------
module tb_seq_mul8;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  x;
   logic [7:0]  y;
   logic        busy;
   logic        done;
   logic [15:0] z;

   int n_cmp = 0;
   int n_err = 0;
   logic [15:0] last_z;   // product the DUT must currently be holding

   seq_mul8 dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .x     (x),
      .y     (y),
      .busy  (busy),
      .done  (done),
      .z     (z)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One full operation starting from IDLE. With scramble set, x/y/start are
   // randomized during RUN; the result must still be the latched product.
   task automatic do_mul(input logic [7:0] a, input logic [7:0] b, input bit scramble);
      logic [15:0] exp_p;
      exp_p = 16'(a) * 16'(b);
      @(negedge clk);
      x = a; y = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check("run_busy", busy, 1'b1);
         check("run_done", done, 1'b0);
         check("run_zhold", z, last_z);
         if (scramble) begin
            x = 8'($urandom);
            y = 8'($urandom);
            start = 1'($urandom);
         end
         @(negedge clk);
      end
      start = 1'b0;
      check("done_pulse", done, 1'b1);
      check("done_busy", busy, 1'b0);
      check("product", z, exp_p);
      last_z = exp_p;
      @(negedge clk);
      check("post_done", done, 1'b0);
      check("post_busy", busy, 1'b0);
      check("post_zhold", z, last_z);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; x = 8'h00; y = 8'h00;
      last_z = 16'h0000;
      #12;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_z", z, 16'h0000);
      @(negedge clk);
      rst = 1'b0;

      // Directed cases.
      do_mul(8'd157, 8'd105, 1'b0);
      check("ex_157x105", z, 16'h4065);
      do_mul(8'd255, 8'd255, 1'b0);
      check("ex_255x255", z, 16'hFE01);
      do_mul(8'd0, 8'd200, 1'b0);
      check("ex_0x200", z, 16'h0000);
      repeat (3) begin
         @(negedge clk);
         check("idle_zhold", z, 16'h0000);
      end
      do_mul(8'd1, 8'd1, 1'b0);
      check("ex_1x1", z, 16'h0001);

      // Back-to-back with start held high throughout.
      @(negedge clk);
      x = 8'd12; y = 8'd13; start = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         check("b2b_busy1", busy, 1'b1);
         @(negedge clk);
      end
      check("b2b_done1", done, 1'b1);
      check("b2b_z1", z, 16'h009C);
      x = 8'd7; y = 8'd9;
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         check("b2b_busy2", busy, 1'b1);
         check("b2b_zhold", z, 16'h009C);
         @(negedge clk);
      end
      check("b2b_done2", done, 1'b1);
      check("b2b_z2", z, 16'h003F);
      start = 1'b0;
      last_z = 16'h003F;
      @(negedge clk);
      check("b2b_idle", done, 1'b0);

      // Mid-run reset aborts without a done pulse.
      x = 8'd200; y = 8'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      check("abort_busy_pre", busy, 1'b1);
      rst = 1'b1;
      #1;
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_z", z, 16'h0000);
      @(negedge clk);
      rst = 1'b0;
      last_z = 16'h0000;
      repeat (10) begin
         @(negedge clk);
         check("abort_nodone", done, 1'b0);
         check("abort_zhold", z, 16'h0000);
      end
      do_mul(8'd200, 8'd3, 1'b0);
      check("abort_redo", z, 16'd600);

      // Randomized operands, half of them with operand churn during RUN.
      for (int k = 0; k < 40; k++) begin
         do_mul(8'($urandom), 8'($urandom), 1'(k % 2));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
